// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshake bundle between core_sequencer (master) and the
// memory side (slave).
interface core_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic if_latch;
  logic dmem_req;
  logic dmem_ready;

  modport master (
    output imem_req,
    output if_latch,
    output dmem_req,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  if_latch,
    input  dmem_req,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: one instruction at a time through fetch, decode, execute, memory and
// writeback. Define SEQ_MEM_TIMEOUT_EN to trap when a memory request exceeds MEM_TIMEOUT cycles.
module core_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  core_sequencer_if.master mem,
  output logic             id_en,
  output logic             ex_en,
  output logic             wb_en,
  input  logic             is_load_store,
  input  logic             was_branch,
  input  logic             illegal_instr,
  input  logic             halt_req,
  output logic             pc_write_en,
  output logic             pc_sel,
  output logic             instr_retired,
  output logic [31:0]      retire_count,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6,
    StTrap      = 3'd7
  } state_e;

  localparam logic [1:0] CauseIllegal  = 2'd1;
  localparam logic [1:0] CauseFetchTo  = 2'd2;
  localparam logic [1:0] CauseDataTo   = 2'd3;

  state_e      state_q, state_d;
  logic        branch_taken_q, branch_taken_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic        expired;

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            waiting;

  // Counter is zero in every non-request state, so it is already clear on entry.
  assign waiting = ((state_q == StFetch) && !mem.imem_ready) ||
                   ((state_q == StMemory) && !mem.dmem_ready);
  assign wait_cnt_d = waiting ? wait_cnt_q + CntW'(1) : '0;
  assign expired    = waiting && (wait_cnt_q == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_mem_timeout;
  assign unused_mem_timeout = ^MEM_TIMEOUT;
  assign expired            = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      branch_taken_q <= 1'b0;
      retire_count_q <= '0;
      trap_cause_q   <= '0;
    end else begin
      state_q        <= state_d;
      branch_taken_q <= branch_taken_d;
      retire_count_q <= retire_count_d;
      trap_cause_q   <= trap_cause_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    branch_taken_d = branch_taken_q;
    retire_count_d = retire_count_q;
    trap_cause_d   = trap_cause_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (mem.imem_ready) begin
          state_d = StDecode;
        end else if (expired) begin
          state_d      = StTrap;
          trap_cause_d = CauseFetchTo;
        end
      end
      StDecode: begin
        if (illegal_instr) begin
          state_d      = StTrap;
          trap_cause_d = CauseIllegal;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        branch_taken_d = was_branch;
        if (halt_req) begin
          state_d = StHalt;
        end else if (is_load_store) begin
          state_d = StMemory;
        end else begin
          state_d = StWriteback;
        end
      end
      StMemory: begin
        if (mem.dmem_ready) begin
          state_d = StWriteback;
        end else if (expired) begin
          state_d      = StTrap;
          trap_cause_d = CauseDataTo;
        end
      end
      StWriteback: begin
        retire_count_d = retire_count_q + 32'd1;
        state_d        = run ? StFetch : StIdle;
      end
      StHalt, StTrap: begin
        state_d = state_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // if_latch is the only output that looks at an input; the rest decode from state alone.
  assign mem.imem_req  = (state_q == StFetch);
  assign mem.if_latch  = (state_q == StFetch) && mem.imem_ready;
  assign mem.dmem_req  = (state_q == StMemory);
  assign id_en         = (state_q == StDecode);
  assign ex_en         = (state_q == StExecute);
  assign wb_en         = (state_q == StWriteback);
  assign pc_write_en   = (state_q == StWriteback);
  assign instr_retired = (state_q == StWriteback);
  assign pc_sel        = (state_q == StWriteback) && branch_taken_q;
  assign halted        = (state_q == StHalt);
  assign trap          = (state_q == StTrap);
  assign trap_cause    = trap_cause_q;
  assign retire_count  = retire_count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: instruction-level timeline model driven with random
// noise on every input the current stage must ignore.
module tb_core_sequencer;
  localparam int MT = 4;
`ifdef SEQ_MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        run;
  logic        id_en, ex_en, wb_en;
  logic        is_load_store, was_branch, illegal_instr, halt_req;
  logic        pc_write_en, pc_sel, instr_retired, halted, trap;
  logic [31:0] retire_count;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  core_sequencer_if mem_if();

  core_sequencer #(
    .MEM_TIMEOUT(MT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .mem           (mem_if),
    .id_en         (id_en),
    .ex_en         (ex_en),
    .wb_en         (wb_en),
    .is_load_store (is_load_store),
    .was_branch    (was_branch),
    .illegal_instr (illegal_instr),
    .halt_req      (halt_req),
    .pc_write_en   (pc_write_en),
    .pc_sel        (pc_sel),
    .instr_retired (instr_retired),
    .retire_count  (retire_count),
    .halted        (halted),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_count;
  logic [1:0]  m_cause;
  bit          m_br;
  bit          m_idle;
  bit          m_dead;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic check_outputs(input logic [2:0] st, input bit ir);
    logic [9:0] exp_v, obs_v;
    logic       exp_sel;
    exp_v = {st == 3'd1, (st == 3'd1) && ir, st == 3'd2, st == 3'd3, st == 3'd4,
             st == 3'd5, st == 3'd5, st == 3'd5, st == 3'd6, st == 3'd7};
    obs_v = {mem_if.imem_req, mem_if.if_latch, id_en, ex_en, mem_if.dmem_req,
             wb_en, pc_write_en, instr_retired, halted, trap};
    checks++;
    assert (state === st) else begin
      errors++;
      $error("FAIL state obs=%0d exp=%0d t=%0t", state, st, $time);
    end
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL outputs(st=%0d) obs=%b exp=%b t=%0t", st, obs_v, exp_v, $time);
    end
    checks++;
    assert (retire_count === m_count) else begin
      errors++;
      $error("FAIL retire_count obs=%0d exp=%0d t=%0t", retire_count, m_count, $time);
    end
    checks++;
    assert (trap_cause === m_cause) else begin
      errors++;
      $error("FAIL trap_cause obs=%0d exp=%0d t=%0t", trap_cause, m_cause, $time);
    end
    if (st == 3'd5 || rst) begin
      exp_sel = (st == 3'd5) ? m_br : 1'b0;
      checks++;
      assert (pc_sel === exp_sel) else begin
        errors++;
        $error("FAIL pc_sel obs=%b exp=%b t=%0t", pc_sel, exp_sel, $time);
      end
    end
  endtask

  // One clock cycle: drive inputs at negedge, check the current (expected) stage.
  task automatic cyc(input logic [2:0] st, input bit run_v, input bit ir, input bit dr,
                     input bit ill, input bit br, input bit hl, input bit ls);
    @(negedge clk);
    run               = run_v;
    mem_if.imem_ready = ir;
    mem_if.dmem_ready = dr;
    illegal_instr     = ill;
    was_branch        = br;
    halt_req          = hl;
    is_load_store     = ls;
    #1;
    check_outputs(st, ir);
  endtask

  task automatic hold(input logic [2:0] st);
    m_dead = 1'b1;
    for (int i = 0; i < 3; i++) cyc(st, rb(), rb(), rb(), rb(), rb(), rb(), rb());
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst               = 1'b1;
    run               = 1'b0;
    mem_if.imem_ready = 1'b0;
    mem_if.dmem_ready = 1'b0;
    illegal_instr     = 1'b0;
    was_branch        = 1'b0;
    halt_req          = 1'b0;
    is_load_store     = 1'b0;
    m_count           = '0;
    m_cause           = '0;
    m_br              = 1'b0;
    m_idle            = 1'b1;
    m_dead            = 1'b0;
    #1;
    check_outputs(3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected timeline: [I] F*(fw+1) D E [M*(mw+1)] W, with terminal exits.
  task automatic run_instr(input int fw, input bit ill, input bit br, input bit hl,
                           input bit ls, input int mw, input bit run_after);
    if (m_idle) begin
      cyc(3'd0, 1'b1, rb(), rb(), rb(), rb(), rb(), rb());
      m_idle = 1'b0;
    end
    for (int i = 0; i <= fw; i++) begin
      if (TO_EN && i == MT) begin
        m_cause = 2'd2;
        hold(3'd7);
        return;
      end
      cyc(3'd1, rb(), i == fw, rb(), rb(), rb(), rb(), rb());
    end
    cyc(3'd2, rb(), rb(), rb(), ill, rb(), rb(), rb());
    if (ill) begin
      m_cause = 2'd1;
      hold(3'd7);
      return;
    end
    cyc(3'd3, rb(), rb(), rb(), rb(), br, hl, ls);
    m_br = br;
    if (hl) begin
      hold(3'd6);
      return;
    end
    if (ls) begin
      for (int i = 0; i <= mw; i++) begin
        if (TO_EN && i == MT) begin
          m_cause = 2'd3;
          hold(3'd7);
          return;
        end
        cyc(3'd4, rb(), rb(), i == mw, rb(), rb(), rb(), rb());
      end
    end
    cyc(3'd5, run_after, rb(), rb(), rb(), rb(), rb(), rb());
    m_count++;
    m_idle = !run_after;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int fw, mw;
    bit ill, hl;
    rst = 1'b1;
    reset_dut();

    // Three zero-wait ALU instructions back to back, then idle.
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc(3'd0, 1'b0, rb(), rb(), rb(), rb(), rb(), rb());
    // Taken branch with a 2-cycle fetch wait; load with a 3-cycle MEMORY.
    run_instr(2, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      fw  = $urandom_range(0, 5);
      mw  = $urandom_range(0, 5);
      ill = ($urandom_range(0, 15) == 0);
      hl  = ($urandom_range(0, 11) == 0);
      run_instr(fw, ill, rb(), hl, rb(), mw, rb());
      if (m_dead) reset_dut();
    end

    // Halt wins over a load/store; nothing retires.
    reset_dut();
    run_instr(1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_instr(0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    // Illegal instruction traps; reset clears everything.
    reset_dut();
    run_instr(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    reset_dut();

`ifdef SEQ_MEM_TIMEOUT_EN
    run_instr(MT, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    reset_dut();
    run_instr(MT - 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, MT - 1, 1'b1);
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, MT, 1'b1);
    reset_dut();
`endif

    // Reset abandons an in-flight instruction.
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(3'd1, 1'b1, 1'b1, rb(), rb(), rb(), rb(), rb());
    cyc(3'd2, rb(), rb(), rb(), 1'b0, rb(), rb(), rb());
    reset_dut();
    cyc(3'd0, 1'b0, rb(), rb(), rb(), rb(), rb(), rb());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
